// File: rtl/shift_reg_en_univ_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : shift_reg_en_univ_pkg
//  Description : Shared definitions for the universal enabled shift register:
//                operation-select width and the mode encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package shift_reg_en_univ_pkg;

    localparam int MODE_W = 3;

    typedef logic [MODE_W-1:0] mode_t;

    localparam mode_t MODE_HOLD = 3'b000;
    localparam mode_t MODE_LOAD = 3'b001;
    localparam mode_t MODE_SHL  = 3'b010;
    localparam mode_t MODE_SHR  = 3'b011;
    localparam mode_t MODE_ROL  = 3'b100;
    localparam mode_t MODE_ROR  = 3'b101;
    localparam mode_t MODE_ASR  = 3'b110;
    localparam mode_t MODE_RSVD = 3'b111;  // decodes as HOLD

endpackage : shift_reg_en_univ_pkg
`default_nettype wire

// File: rtl/shift_reg_en_univ_dff_r_en.sv
`default_nettype none
// ============================================================================
//  Module      : shift_reg_en_univ_dff_r_en
//  Description : One-bit D flip-flop (the dff_r_en cell) with synchronous
//                active-high reset to a supplied reset value and clock enable.
//                Reset takes priority over enable.
//  Ports       : clk     - rising-edge clock
//                reset   - synchronous active-high reset
//                rst_val - value loaded into q on reset
//                en      - clock enable; 0 holds q
//                d       - data input
//                q       - registered output
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_reg_en_univ_dff_r_en (
    input  logic clk,
    input  logic reset,
    input  logic rst_val,
    input  logic en,
    input  logic d,
    output logic q
);

    logic r_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= rst_val;
        end else if (en) begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule : shift_reg_en_univ_dff_r_en
`default_nettype wire

// File: rtl/shift_reg_en_univ.sv
`default_nettype none
// ============================================================================
//  Module      : shift_reg_en_univ
//  Description : Parametrised universal register: parallel load, logical
//                shifts, rotates and arithmetic shift right, with clock
//                enable and synchronous reset. Every flop is a dff_r_en cell;
//                the per-bit next-state mux lives here.
//  Ports       : clk   - rising-edge clock
//                reset - synchronous active-high reset (q=RESET_VAL, so=0)
//                en    - clock enable; 0 holds q and so
//                mode  - operation select (see package encodings)
//                d     - parallel load data
//                si    - serial input for SHL/SHR
//                q     - register contents
//                so    - bit shifted out by the last SHL/SHR/ASR
//                zero  - combinational, 1 when q == 0
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_reg_en_univ
    import shift_reg_en_univ_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [MODE_W-1:0] mode,
    input  logic [WIDTH-1:0]  d,
    input  logic              si,
    output logic [WIDTH-1:0]  q,
    output logic              so,
    output logic              zero
);

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_next_q;
    logic             w_so;
    logic             w_next_so;

    // Hold modes feed the current value back, so d/si only reach the flops
    // in the modes that actually consume them.
    always_comb begin
        w_next_q  = w_q;
        w_next_so = w_so;
        case (mode)
            MODE_LOAD: begin
                w_next_q  = d;
                w_next_so = 1'b0;
            end
            MODE_SHL: begin
                w_next_q  = {w_q[WIDTH-2:0], si};
                w_next_so = w_q[WIDTH-1];
            end
            MODE_SHR: begin
                w_next_q  = {si, w_q[WIDTH-1:1]};
                w_next_so = w_q[0];
            end
            MODE_ROL: begin
                w_next_q  = {w_q[WIDTH-2:0], w_q[WIDTH-1]};
            end
            MODE_ROR: begin
                w_next_q  = {w_q[0], w_q[WIDTH-1:1]};
            end
            MODE_ASR: begin
                w_next_q  = {w_q[WIDTH-1], w_q[WIDTH-1:1]};
                w_next_so = w_q[0];
            end
            default: begin
                // HOLD and reserved encoding: keep current state
                w_next_q  = w_q;
                w_next_so = w_so;
            end
        endcase
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        shift_reg_en_univ_dff_r_en u_dff (
            .clk     (clk),
            .reset   (reset),
            .rst_val (RESET_VAL[i]),
            .en      (en),
            .d       (w_next_q[i]),
            .q       (w_q[i])
        );
    end

    shift_reg_en_univ_dff_r_en u_so_dff (
        .clk     (clk),
        .reset   (reset),
        .rst_val (1'b0),
        .en      (en),
        .d       (w_next_so),
        .q       (w_so)
    );

    assign q    = w_q;
    assign so   = w_so;
    assign zero = (w_q == '0);

endmodule : shift_reg_en_univ
`default_nettype wire
